// File: rtl/nor_segment_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : nor_segment_scheduler
//  Description : Round-robin scheduler that evaluates each requester's wide
//                NOR serially through one shared SEG_WIDTH-bit NOR segment.
//  Revision    : 1.0 - initial release
// ============================================================================

module nor_segment_scheduler #(
    parameter int NUM_REQ     = 4,
    parameter int INPUT_WIDTH = 16,
    parameter int SEG_WIDTH   = 4
) (
    input  logic                           Clock,
    input  logic                           nReset,
    input  logic [1:0]                     DigitSupply,
    input  logic [NUM_REQ-1:0]             reqValid,
    input  logic [NUM_REQ*INPUT_WIDTH-1:0] reqData,
    output logic [NUM_REQ-1:0]             reqReady,
    output logic [NUM_REQ-1:0]             respValid,
    output logic                           respData,
    input  logic                           respReady,
    output logic                           busy
);

    localparam int SEGMENTS  = INPUT_WIDTH / SEG_WIDTH;
    localparam int SEG_IDX_W = (SEGMENTS > 1) ? $clog2(SEGMENTS) : 1;
    localparam int GRANT_W   = $clog2(NUM_REQ);

    localparam logic [SEG_IDX_W-1:0] C_LAST_SEG = SEG_IDX_W'(SEGMENTS - 1);
    localparam logic [GRANT_W-1:0]   C_LAST_REQ = GRANT_W'(NUM_REQ - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EVAL = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t                  r_state;
    logic [GRANT_W-1:0]      r_lastGrant;
    logic [GRANT_W-1:0]      r_owner;
    logic [SEG_IDX_W-1:0]    r_segIdx;
    logic [INPUT_WIDTH-1:0]  r_op;
    logic [NUM_REQ-1:0]      r_respValid;
    logic                    r_respData;

    logic [NUM_REQ-1:0]      w_mask;
    logic [NUM_REQ-1:0]      w_masked;
    logic                    w_anyReq;
    logic [GRANT_W-1:0]      w_grant;
    logic [NUM_REQ-1:0]      w_grantOH;
    logic [NUM_REQ-1:0]      w_ownerOH;
    logic [INPUT_WIDTH-1:0]  w_grantData;
    logic [SEG_WIDTH-1:0]    w_segIn;
    logic                    w_segNor;

    // --------------------------------------------------------------------
    // Round-robin arbiter: requesters above lastGrant take precedence,
    // otherwise the search wraps to the lowest-numbered valid requester.
    // --------------------------------------------------------------------
    always_comb begin
        w_mask = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            w_mask[i] = (GRANT_W'(i) > r_lastGrant);
        end
        w_masked = reqValid & w_mask;
        w_anyReq = |reqValid;

        w_grant = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (reqValid[i]) begin
                w_grant = GRANT_W'(i);
            end
        end
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (w_masked[i]) begin
                w_grant = GRANT_W'(i);
            end
        end
    end

    always_comb begin
        w_grantOH   = '0;
        w_ownerOH   = '0;
        w_grantData = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            w_grantOH[i] = (w_grant == GRANT_W'(i));
            w_ownerOH[i] = (r_owner == GRANT_W'(i));
            if (w_grant == GRANT_W'(i)) begin
                w_grantData = reqData[i*INPUT_WIDTH +: INPUT_WIDTH];
            end
        end
    end

    // The operand register shifts down one segment per EVAL cycle, so the
    // shared NOR always looks at the low slice.
    assign w_segIn = r_op[SEG_WIDTH-1:0];

    generate
        if (1) begin : g_shared_nor
            // Output is only meaningful with the high rail on bit 1.
            assign w_segNor = (DigitSupply == 2'b10) ? ~|w_segIn : 1'b0;
        end
    endgenerate

    assign reqReady  = ((r_state == ST_IDLE) && w_anyReq) ? w_grantOH : '0;
    assign respValid = r_respValid;
    assign respData  = r_respData;
    assign busy      = (r_state != ST_IDLE);

    always_ff @(posedge Clock) begin
        if (!nReset) begin
            r_state     <= ST_IDLE;
            r_lastGrant <= C_LAST_REQ;
            r_owner     <= '0;
            r_segIdx    <= '0;
            r_op        <= '0;
            r_respValid <= '0;
            r_respData  <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_anyReq) begin
                        r_op     <= w_grantData;
                        r_owner  <= w_grant;
                        r_segIdx <= '0;
                        r_state  <= ST_EVAL;
                    end
                end
                ST_EVAL: begin
                    if (!w_segNor) begin
                        // A set bit anywhere decides the result immediately.
                        r_respData  <= 1'b0;
                        r_respValid <= w_ownerOH;
                        r_state     <= ST_RESP;
                    end else if (r_segIdx == C_LAST_SEG) begin
                        r_respData  <= 1'b1;
                        r_respValid <= w_ownerOH;
                        r_state     <= ST_RESP;
                    end else begin
                        r_segIdx <= r_segIdx + 1'b1;
                        r_op     <= r_op >> SEG_WIDTH;
                    end
                end
                ST_RESP: begin
                    if (respReady) begin
                        r_respValid <= '0;
                        r_respData  <= 1'b0;
                        r_lastGrant <= r_owner;
                        r_state     <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_nor_segment_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : tb_nor_segment_scheduler
//  Description : Directed bench for nor_segment_scheduler with a
//                transaction-level reference model checked every cycle.
//  Revision    : 1.0 - initial release
// ============================================================================

module tb_nor_segment_scheduler;

    localparam int N    = 4;
    localparam int W    = 16;
    localparam int S    = 4;
    localparam int SEGS = W / S;

    logic             Clock = 1'b0;
    logic             nReset = 1'b0;
    logic [1:0]       DigitSupply = 2'b10;
    logic [N-1:0]     reqValid = '0;
    logic [W-1:0]     d [N];
    logic [N*W-1:0]   reqData;
    logic [N-1:0]     reqReady;
    logic [N-1:0]     respValid;
    logic             respData;
    logic             respReady = 1'b0;
    logic             busy;

    int n_checks = 0;
    int n_fail   = 0;

    assign reqData = {d[3], d[2], d[1], d[0]};

    always #5 Clock = ~Clock;

    nor_segment_scheduler #(
        .NUM_REQ    (N),
        .INPUT_WIDTH(W),
        .SEG_WIDTH  (S)
    ) dut (
        .Clock      (Clock),
        .nReset     (nReset),
        .DigitSupply(DigitSupply),
        .reqValid   (reqValid),
        .reqData    (reqData),
        .reqReady   (reqReady),
        .respValid  (respValid),
        .respData   (respData),
        .respReady  (respReady),
        .busy       (busy)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model (operation level) ----------------
    bit m_busy   = 1'b0;
    bit m_resp   = 1'b0;
    bit m_result = 1'b0;
    int m_owner  = 0;
    int m_last   = N - 1;
    int m_left   = 0;
    int m_g;
    int e_g;

    function automatic int pick(input logic [N-1:0] v, input int last);
        for (int k = 1; k <= N; k++) begin
            if (v[(last + k) % N]) return (last + k) % N;
        end
        return -1;
    endfunction

    // EVAL cycles = 1-based index of first non-zero segment, else SEGS.
    function automatic int first_seg(input logic [W-1:0] x);
        for (int s = 0; s < SEGS; s++) begin
            if (x[s*S +: S] != '0) return s + 1;
        end
        return SEGS;
    endfunction

    always @(posedge Clock) begin
        if (!nReset) begin
            m_busy = 1'b0;
            m_resp = 1'b0;
            m_last = N - 1;
        end else if (!m_busy) begin
            m_g = pick(reqValid, m_last);
            if (m_g >= 0) begin
                m_owner  = m_g;
                m_left   = first_seg(d[m_g]);
                m_result = (d[m_g] == '0);
                m_busy   = 1'b1;
            end
        end else if (!m_resp) begin
            m_left--;
            if (m_left == 0) m_resp = 1'b1;
        end else if (respReady) begin
            m_resp = 1'b0;
            m_busy = 1'b0;
            m_last = m_owner;
        end
    end

    always @(negedge Clock) begin
        if (nReset) begin
            e_g = m_busy ? -1 : pick(reqValid, m_last);
            chk("cyc_reqReady",  reqReady,  (e_g >= 0) ? (32'd1 << e_g) : 32'd0);
            chk("cyc_respValid", respValid, m_resp ? (32'd1 << m_owner) : 32'd0);
            chk("cyc_respData",  respData,  m_resp ? m_result : 1'b0);
            chk("cyc_busy",      busy,      m_busy);
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic step();
        @(posedge Clock);
        #1;
    endtask

    task automatic neg();
        @(negedge Clock);
    endtask

    task automatic do_reset();
        step();
        nReset = 1'b0;
        step();
        step();
        nReset = 1'b1;
    endtask

    int gq[$];
    int rq[$];
    int exp_order[5] = '{1, 2, 4, 8, 1};

    initial begin
        for (int i = 0; i < N; i++) d[i] = '0;

        // 1: all-zero operand from requester 0, full 4-cycle evaluation
        step(); step(); step();
        nReset = 1'b1;
        neg();
        chk("rst_reqReady", reqReady, 0);
        chk("rst_respValid", respValid, 0);
        chk("rst_respData", respData, 0);
        chk("rst_busy", busy, 0);
        step(); reqValid = 4'b0001; d[0] = 16'h0000; respReady = 1'b1;
        neg(); chk("t1_grant", reqReady, 4'b0001);
        step(); reqValid = '0;
        neg(); chk("t1_busy", busy, 1);
        repeat (3) step();
        neg(); chk("t1_not_yet", respValid, 0);
        step();
        neg(); chk("t1_respValid", respValid, 4'b0001); chk("t1_respData", respData, 1);
        step();
        neg(); chk("t1_idle", busy, 0);

        // 2: early exit on second segment
        step(); reqValid = 4'b0100; d[2] = 16'h0010;
        neg(); chk("t2_grant", reqReady, 4'b0100);
        step(); reqValid = '0;
        step();
        neg(); chk("t2_not_yet", respValid, 0);
        step();
        neg(); chk("t2_respValid", respValid, 4'b0100); chk("t2_respData", respData, 0);
        step();
        neg(); chk("t2_idle", busy, 0);

        // 3: all requesters held, round-robin order
        do_reset();
        d[2] = '0;
        reqValid = 4'b1111; respReady = 1'b1;
        for (int c = 0; c < 80; c++) begin
            neg();
            if (reqReady != '0) gq.push_back(int'(reqReady));
            if (respValid != '0) rq.push_back(int'(respValid));
            if (rq.size() >= 5) break;
            step();
            if (gq.size() >= 5) reqValid = '0;
        end
        chk("t3_grant_count", gq.size(), 5);
        chk("t3_resp_count", rq.size(), 5);
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("t3_grant%0d", i), (i < gq.size()) ? gq[i] : -1, exp_order[i]);
            chk($sformatf("t3_resp%0d", i),  (i < rq.size()) ? rq[i] : -1, exp_order[i]);
        end

        // 4: back-pressure in RESP while others wait
        step(); reqValid = 4'b0010; respReady = 1'b0;
        neg(); chk("t4_grant", reqReady, 4'b0010);
        step(); reqValid = 4'b1101;
        repeat (3) step();
        step();
        for (int i = 0; i < 5; i++) begin
            neg();
            chk("t4_hold_valid", respValid, 4'b0010);
            chk("t4_hold_data", respData, 1);
            chk("t4_hold_noready", reqReady, 0);
            chk("t4_hold_busy", busy, 1);
            step();
        end
        respReady = 1'b1;
        neg(); chk("t4_handshake_valid", respValid, 4'b0010);
        step();
        neg(); chk("t4_after_busy", busy, 0); chk("t4_next_grant", reqReady, 4'b0100);
        step(); reqValid = '0;
        repeat (8) step();

        // 5: reset during EVAL of requester 1
        reqValid = 4'b0010;
        neg(); chk("t5_grant", reqReady, 4'b0010);
        step(); reqValid = '0;
        step(); nReset = 1'b0;
        step(); nReset = 1'b1;
        neg();
        chk("t5_rst_respValid", respValid, 0);
        chk("t5_rst_respData", respData, 0);
        chk("t5_rst_reqReady", reqReady, 0);
        chk("t5_rst_busy", busy, 0);
        repeat (6) begin
            step();
            neg(); chk("t5_no_resp", respValid, 0);
        end
        step(); reqValid = 4'b0110;
        neg(); chk("t5_priority", reqReady, 4'b0010);
        step(); reqValid = '0;
        repeat (6) step();

        // 6: one only in last segment, then all ones
        reqValid = 4'b0001; d[0] = 16'h8000;
        neg(); chk("t6a_grant", reqReady, 4'b0001);
        step(); reqValid = '0;
        repeat (3) step();
        neg(); chk("t6a_not_yet", respValid, 0);
        step();
        neg(); chk("t6a_respValid", respValid, 4'b0001); chk("t6a_respData", respData, 0);
        step(); reqValid = 4'b1000; d[3] = 16'hFFFF;
        neg(); chk("t6b_grant", reqReady, 4'b1000);
        step(); reqValid = '0;
        neg(); chk("t6b_not_yet", respValid, 0);
        step();
        neg(); chk("t6b_respValid", respValid, 4'b1000); chk("t6b_respData", respData, 0);
        step(); step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire
